rr_grant_scheduler_4: RTL and testbench

- Four-requester round-robin scheduler that shares one resource: a one-hot selected line.
- Arbitrates `req[3:0]`, registers the winner as a 2-bit owner index, and drives a one-hot `grant[3:0]` equal to the 2-to-4 decoding of that index, enabled by `gnt_valid`.
- Grants are held while the owner keeps requesting.
- A hold limit forces hand-over under contention.
- Sits between requesting agents and the shared resource's select logic.

---
 rtl/rr_grant_scheduler_4.sv | 94 +++++++++
 tb/tb_rr_grant_scheduler_4.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler_4.sv
// Four-requester round-robin scheduler with grant hold and hold-limit preemption.
// Owner, round-robin pointer and all outputs are registered; grant is the one-hot of the owner.
module rr_grant_scheduler_4 #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   output logic [3:0]       grant,
   output logic [1:0]       gnt_id,
   output logic             gnt_valid
);

   // With MAX_HOLD = 0 this wraps to all-ones, which only serves as the counter saturation point
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);
   localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [1:0]       owner;
   logic [1:0]       last;
   logic [CNT_W-1:0] hold_cnt;

   // First set bit of r searching p, p+1, p+2, p+3 (mod 4)
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      rr_pick = p;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   logic [3:0] owner_bit_c;
   logic [3:0] others_c;
   logic       keep_c;
   logic [1:0] pick_idle_c;
   logic [1:0] pick_next_c;

   always_comb begin
      owner_bit_c = 4'(4'b0001 << owner);
      others_c    = req & ~owner_bit_c;
      keep_c      = req[owner] && !(PREEMPT_EN && (hold_cnt == HOLD_LAST) && (|others_c));
      pick_idle_c = rr_pick(req, last + 2'd1);
      pick_next_c = rr_pick(others_c, owner + 2'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 2'd0;
         last      <= 2'd3;
         hold_cnt  <= '0;
         grant     <= 4'b0000;
         gnt_id    <= 2'd0;
         gnt_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state     <= BUSY;
                  owner     <= pick_idle_c;
                  last      <= pick_idle_c;
                  hold_cnt  <= '0;
                  grant     <= 4'(4'b0001 << pick_idle_c);
                  gnt_id    <= pick_idle_c;
                  gnt_valid <= 1'b1;
               end
            end
            BUSY: begin
               if (keep_c) begin
                  if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + CNT_W'(1);
               end else if (|others_c) begin
                  // Release or preemption: hand over directly without an idle cycle
                  owner    <= pick_next_c;
                  last     <= pick_next_c;
                  hold_cnt <= '0;
                  grant    <= 4'(4'b0001 << pick_next_c);
                  gnt_id   <= pick_next_c;
               end else begin
                  state     <= IDLE;
                  hold_cnt  <= '0;
                  grant     <= 4'b0000;
                  gnt_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_scheduler_4.sv
// Directed bench for rr_grant_scheduler_4 with MAX_HOLD of 8, 0 and 1.
// Expected grants are queued as each step is driven and checked after the following edge.
module tb_rr_grant_scheduler_4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req8, req0, req1;
   logic [3:0] g8, g0, g1;
   logic [1:0] id8, id0, id1;
   logic       v8, v0, v1;

   always #5 clk = ~clk;

   rr_grant_scheduler_4 #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .req(req8), .grant(g8), .gnt_id(id8), .gnt_valid(v8));
   rr_grant_scheduler_4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .grant(g0), .gnt_id(id0), .gnt_valid(v0));
   rr_grant_scheduler_4 #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .grant(g1), .gnt_id(id1), .gnt_valid(v1));

   typedef struct {
      int         sel;
      logic [3:0] g;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [1:0] enc(input logic [3:0] oh);
      case (oh)
         4'b0010: enc = 2'd1;
         4'b0100: enc = 2'd2;
         4'b1000: enc = 2'd3;
         default: enc = 2'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
   endtask

   task automatic check_all(input string tag, input int sel, input logic [3:0] eg);
      logic [3:0] og;
      logic [1:0] oid;
      logic       ov;
      case (sel)
         0:       begin og = g8; oid = id8; ov = v8; end
         1:       begin og = g0; oid = id0; ov = v0; end
         default: begin og = g1; oid = id1; ov = v1; end
      endcase
      chk({tag, "/grant"}, og, eg);
      chk({tag, "/valid"}, {3'b000, ov}, {3'b000, |eg});
      if (|eg) chk({tag, "/id"}, {2'b00, oid}, {2'b00, enc(eg)});
   endtask

   // Called at a falling edge: drive req, queue the expectation, check after the next rising edge
   task automatic step(input int sel, input logic [3:0] r, input logic [3:0] eg, input string tag);
      exp_t e;
      req8 = (sel == 0) ? r : 4'b0000;
      req0 = (sel == 1) ? r : 4'b0000;
      req1 = (sel == 2) ? r : 4'b0000;
      sb.push_back('{sel, eg, tag});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_all(e.tag, e.sel, e.g);
      @(negedge clk);
   endtask

   initial begin
      req8 = 4'b1111;
      req0 = 4'b0000;
      req1 = 4'b0000;
      #2 rst = 1'b1;
      #1;
      check_all("rst_imm8", 0, 4'b0000);
      check_all("rst_imm0", 1, 4'b0000);
      check_all("rst_imm1", 2, 4'b0000);

      @(negedge clk);
      rst = 1'b0;
      step(0, 4'b1111, 4'b0001, "rst_release");

      // Full contention with a hold limit of 8: blocks of 8 per requester
      for (int i = 1; i < 40; i++) step(0, 4'b1111, 4'(1 << ((i / 8) % 4)), "rotate8");
      step(0, 4'b0000, 4'b0000, "rotate_drop");

      for (int i = 0; i < 5; i++) step(0, 4'b0100, 4'b0100, "solo");
      step(0, 4'b0000, 4'b0000, "solo_end");
      step(0, 4'b0000, 4'b0000, "idle");

      step(0, 4'b0010, 4'b0010, "own1");
      step(0, 4'b0010, 4'b0010, "own1_hold");
      step(0, 4'b1001, 4'b1000, "handover");
      step(0, 4'b1001, 4'b1000, "own3_hold");
      step(0, 4'b0000, 4'b0000, "handover_end");

      // Uncontended hold saturates the counter, so the first contender preempts at once
      for (int i = 0; i < 12; i++) step(0, 4'b0001, 4'b0001, "uncontended");
      step(0, 4'b0011, 4'b0010, "sat_preempt");
      for (int i = 0; i < 7; i++) step(0, 4'b0011, 4'b0010, "own1_limit");
      step(0, 4'b0011, 4'b0001, "limit_back");
      step(0, 4'b0000, 4'b0000, "limit_end");

      for (int i = 0; i < 50; i++) step(1, 4'b0011, 4'b0001, "unlimited");
      step(1, 4'b0010, 4'b0010, "unlimited_rel");
      step(1, 4'b0000, 4'b0000, "unlimited_end");

      for (int i = 0; i < 12; i++) step(2, 4'b1111, 4'(1 << (i % 4)), "rotate1");
      step(2, 4'b0000, 4'b0000, "rotate1_end");

      step(0, 4'b0100, 4'b0100, "pre_rst");
      #2 rst = 1'b1;
      #1;
      check_all("mid_rst", 0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      step(0, 4'b0100, 4'b0100, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
